// File: rtl/conv_window_gen_pkg.sv
// Shared types and constants for the 3x3 RGB window generator.
//   pix_t : one 8-bit unsigned channel sample
//   rgb_t : one pixel, [CH_R]=R, [CH_G]=G, [CH_B]=B
//   win_t : one 3x3 window of a single channel, [k][l] = pixel(row-2+k, col-2+l)
package conv_pkg;

  typedef logic [7:0]      pix_t;
  typedef pix_t [2:0]      rgb_t;
  typedef pix_t [2:0][2:0] win_t;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;
  localparam int K    = 3;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bus of conv_window_gen.
//   pixel side : pix_valid, pix_ready, pix_in (raster-order RGB stream)
//   window side: win_valid, win_ready, win_r/g/b, win_row, win_col, win_last
// Modports:
//   master : the environment (pixel source + window sink)
//   slave  : the window generator itself
interface conv_window_gen_if #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
);
  import conv_pkg::*;

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic          pix_valid;
  logic          pix_ready;
  rgb_t          pix_in;
  logic          win_valid;
  logic          win_ready;
  win_t          win_r;
  win_t          win_g;
  win_t          win_b;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          win_last;

  modport master (
    output pix_valid, pix_in, win_ready,
    input  pix_ready, win_valid, win_r, win_g, win_b, win_row, win_col, win_last
  );

  modport slave (
    input  pix_valid, pix_in, win_ready,
    output pix_ready, win_valid, win_r, win_g, win_b, win_row, win_col, win_last
  );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// conv_line_buffer: one colour channel of the window generator.
// Holds the two previous image rows (lb0 = row-2, lb1 = row-1), each IMG_W
// deep and indexed by column, plus a 3x3 column shift register.
//   clk       : clock
//   acc_i     : pixel accepted this cycle (shared across channels)
//   col_i     : column of the accepted pixel
//   pix_i     : this channel's sample of the accepted pixel
//   win_nxt_o : window that results if the current pixel is accepted
// Storage is deliberately not reset: the top suppresses windows until two
// fresh rows have been accepted, so stale contents are never observed.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          acc_i,
  input  logic [CW-1:0] col_i,
  input  pix_t          pix_i,
  output win_t          win_nxt_o
);

  pix_t       lb0_q [IMG_W];
  pix_t       lb1_q [IMG_W];
  pix_t [2:0] col_new;
  win_t       sr_q;

  // New column l=2, top to bottom: row-2, row-1, current row.
  assign col_new = {pix_i, lb1_q[col_i], lb0_q[col_i]};

  // Window after the shift, so the top can register it on the accepting edge.
  always_comb begin
    win_nxt_o = sr_q;
    for (int k = 0; k < K; k++)
      win_nxt_o[k] = {col_new[k], sr_q[k][2], sr_q[k][1]};
  end

  always_ff @(posedge clk) begin
    if (acc_i) begin
      lb0_q[col_i] <= lb1_q[col_i];
      lb1_q[col_i] <= pix_i;
      sr_q         <= win_nxt_o;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator for RGB raster images.
// Tracks (row, col) of accepted pixels, feeds three per-channel line buffers
// and registers a window whenever the accepted pixel completes a full
// neighbourhood inside the image (row >= 2 and col >= 2).
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : conv_window_gen_if.slave (pixel stream in, window stream out)
// The output register is a single pipeline stage: a new pixel is taken only
// when the held window is absent or leaving this cycle.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  conv_window_gen_if.slave  bus
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic           ready;
  logic           acc;
  logic           prod;
  logic           win_valid_q, win_valid_d;
  logic           win_last_q;
  logic [RW-1:0]  win_row_q;
  logic [CW-1:0]  win_col_q;
  win_t [K-1:0]   win_nxt;
  win_t [K-1:0]   win_q;

  assign ready = !win_valid_q || bus.win_ready;
  assign acc   = bus.pix_valid && ready;
  // Windows with col < 2 would mix columns from the previous row: suppress.
  assign prod  = acc && (row_q >= RW'(2)) && (col_q >= CW'(2));

  for (genvar ch = 0; ch < K; ch++) begin : g_ch
    conv_line_buffer #(.IMG_W(IMG_W), .CW(CW)) u_lb (
      .clk       (clk),
      .acc_i     (acc),
      .col_i     (col_q),
      .pix_i     (bus.pix_in[ch]),
      .win_nxt_o (win_nxt[ch])
    );
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (acc) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // A producing accept always (re)loads the register, even while the old
  // window is leaving, so back-to-back windows keep win_valid high.
  assign win_valid_d = prod || (win_valid_q && !bus.win_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_q       <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      if (prod) begin
        win_q      <= win_nxt;
        win_row_q  <= row_q - RW'(2);
        win_col_q  <= col_q - CW'(2);
        win_last_q <= (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end
  end

  assign bus.pix_ready = ready;
  assign bus.win_valid = win_valid_q;
  assign bus.win_r     = win_q[CH_R];
  assign bus.win_g     = win_q[CH_G];
  assign bus.win_b     = win_q[CH_B];
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign bus.win_last  = win_last_q;

endmodule
